cmp_track: RTL and testbench

CMP_TRACK -- requirements
Module: cmp_track

---
 rtl/cmp_pkg.sv | 30 +++
 rtl/cmp_stage.sv | 13 +
 rtl/cmp_track.sv | 156 +++++++++++++++
 tb/tb_cmp_track.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the cmp_track window statistics block.
// Holds the FSM state enum, the sample width and the compare-result bundle.
package cmp_pkg;

    localparam int DW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_t;

    function automatic cmp_t cmp_fn(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        cmp_t r;
        r.gt = (a > b);
        r.eq = (a == b);
        r.lt = (a < b);
        return r;
    endfunction

endpackage

// File: rtl/cmp_stage.sv
// Combinational unsigned comparator: o_res = {a>b, a==b, a<b}.
// Ports: i_a, i_b (DW-bit samples), o_res (cmp_t result).
module cmp_stage
    import cmp_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output cmp_t          o_res
);

    assign o_res = cmp_fn(i_a, i_b);

endmodule

// File: rtl/cmp_track.sv
// Window tracker: collects WIN samples, presents max/min/all-equal.
// Ports: clk, rst_n, clr, in_valid/in_ready/in_data (sample stream),
// out_valid/out_ready, out_max, out_min, out_same (result);
// out_up/out_dn trend counts only when CMP_TRACK_TREND_EN is defined.
module cmp_track
    import cmp_pkg::*;
#(
    parameter int WIN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_max,
    output logic [DW-1:0] out_min,
`ifdef CMP_TRACK_TREND_EN
    output logic [DW-1:0] out_up,
    output logic [DW-1:0] out_dn,
`endif
    output logic          out_same
);

    localparam logic [3:0] WIN_C = 4'(WIN);

    state_t r_state;
    state_t w_state_nxt;

    // r_live keeps in_ready low until the first edge after reset release.
    logic          r_live;
    logic [3:0]    r_cnt;
    logic [DW-1:0] r_max, r_min, r_prev;
    logic          r_same;
    logic [DW-1:0] r_omax, r_omin;
    logic          r_osame;

    cmp_t w_cmax, w_cmin, w_cprev;

    logic          w_first, w_acc, w_hs, w_last;
    logic [3:0]    w_cnt_nxt;
    logic [DW-1:0] w_nmax, w_nmin;
    logic          w_nsame;

    cmp_stage u_cmp_max  (.i_a(in_data), .i_b(r_max),  .o_res(w_cmax));
    cmp_stage u_cmp_min  (.i_a(in_data), .i_b(r_min),  .o_res(w_cmin));
    cmp_stage u_cmp_prev (.i_a(in_data), .i_b(r_prev), .o_res(w_cprev));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        in_ready    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = r_live;
                if (w_acc) w_state_nxt = S_ACC;
            end
            S_ACC: begin
                in_ready = r_live;
                if (w_acc && w_last) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // clr wins over any accept or handshake.
        if (clr) w_state_nxt = S_IDLE;
    end

    assign w_first   = (r_state == S_IDLE);
    assign w_acc     = in_valid & in_ready & ~clr;
    assign w_hs      = out_valid & out_ready;
    assign w_cnt_nxt = w_first ? 4'd1 : r_cnt + 4'd1;
    assign w_last    = (w_cnt_nxt == WIN_C);

    assign w_nmax  = (w_first || w_cmax.gt) ? in_data : r_max;
    assign w_nmin  = (w_first || w_cmin.lt) ? in_data : r_min;
    assign w_nsame = w_first ? 1'b1 : (r_same & w_cprev.eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_cnt   <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_prev  <= '0;
            r_same  <= 1'b0;
            r_omax  <= '0;
            r_omin  <= '0;
            r_osame <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (clr || w_hs) begin
                r_cnt <= '0;
            end else if (w_acc) begin
                r_cnt  <= w_cnt_nxt;
                r_max  <= w_nmax;
                r_min  <= w_nmin;
                r_same <= w_nsame;
                r_prev <= in_data;
                if (w_last) begin
                    r_omax  <= w_nmax;
                    r_omin  <= w_nmin;
                    r_osame <= w_nsame;
                end
            end
        end
    end

    assign out_max  = r_omax;
    assign out_min  = r_omin;
    assign out_same = r_osame;

    logic w_unused;

`ifdef CMP_TRACK_TREND_EN
    logic [DW-1:0] r_up, r_dn, r_oup, r_odn;
    logic [DW-1:0] w_nup, w_ndn;

    assign w_nup = w_first ? '0 : r_up + DW'(w_cprev.gt);
    assign w_ndn = w_first ? '0 : r_dn + DW'(w_cprev.lt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up  <= '0;
            r_dn  <= '0;
            r_oup <= '0;
            r_odn <= '0;
        end else if (w_acc) begin
            r_up <= w_nup;
            r_dn <= w_ndn;
            if (w_last) begin
                r_oup <= w_nup;
                r_odn <= w_ndn;
            end
        end
    end

    assign out_up = r_oup;
    assign out_dn = r_odn;
    assign w_unused = ^{w_cmax.eq, w_cmax.lt, w_cmin.gt, w_cmin.eq};
`else
    assign w_unused = ^{w_cmax.eq, w_cmax.lt, w_cmin.gt, w_cmin.eq,
                        w_cprev.gt, w_cprev.lt};
`endif

endmodule

// File: tb/tb_cmp_track.sv
// Directed bench for cmp_track (WIN=4).
// Trend outputs are checked only when CMP_TRACK_TREND_EN is defined.
module tb_cmp_track;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_max, out_min;
    logic       out_same;
`ifdef CMP_TRACK_TREND_EN
    logic [3:0] out_up, out_dn;
`endif

    int tests = 0;
    int fails = 0;

    cmp_track #(.WIN(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_max(out_max),
        .out_min(out_min),
`ifdef CMP_TRACK_TREND_EN
        .out_up(out_up),
        .out_dn(out_dn),
`endif
        .out_same(out_same)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL rst_ready: got %b want 0", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        tests++;
        if (out_max !== 4'd0 || out_min !== 4'd0 || out_same !== 1'b0) begin
            fails++;
            $display("FAIL rst_out: got %0d/%0d/%b want 0/0/0",
                     out_max, out_min, out_same);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL rel_ready_early: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rel_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send(4'd3); send(4'd9); send(4'd1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_early: got %b want 0", out_valid);
        end
        send(4'd7);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_valid: got v=%b r=%b want v=1 r=0",
                     out_valid, in_ready);
        end
        tests++;
        if (out_max !== 4'd9 || out_min !== 4'd1 || out_same !== 1'b0) begin
            fails++;
            $display("FAIL basic_res: got %0d/%0d/%b want 9/1/0",
                     out_max, out_min, out_same);
        end
`ifdef CMP_TRACK_TREND_EN
        tests++;
        if (out_up !== 4'd2 || out_dn !== 4'd1) begin
            fails++;
            $display("FAIL basic_trend: got %0d/%0d want 2/1", out_up, out_dn);
        end
`endif
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== 4'd9) begin
            fails++;
            $display("FAIL basic_after: got v=%b r=%b max=%0d want 0/1/9",
                     out_valid, in_ready, out_max);
        end
    endtask

    task automatic test_same;
        out_ready = 1'b1;
        send(4'd5); send(4'd5); send(4'd5); send(4'd5);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_max !== 4'd5 ||
            out_min !== 4'd5 || out_same !== 1'b1) begin
            fails++;
            $display("FAIL same_res: got v=%b %0d/%0d/%b want 1 5/5/1",
                     out_valid, out_max, out_min, out_same);
        end
`ifdef CMP_TRACK_TREND_EN
        tests++;
        if (out_up !== 4'd0 || out_dn !== 4'd0) begin
            fails++;
            $display("FAIL same_trend: got %0d/%0d want 0/0", out_up, out_dn);
        end
`endif
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send(4'd2); send(4'd4); send(4'd6); send(4'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_max !== 4'd8 || out_min !== 4'd2 || out_same !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b r=%b %0d/%0d/%b want 1 0 8/2/0",
                         i, out_valid, in_ready, out_max, out_min, out_same);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== 4'd8) begin
            fails++;
            $display("FAIL bp_release: got v=%b r=%b max=%0d want 0/1/8",
                     out_valid, in_ready, out_max);
        end
    endtask

    task automatic test_clr_out;
        out_ready = 1'b0;
        send(4'd1); send(4'd1); send(4'd1); send(4'd1);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL clro_valid: got %b want 1", out_valid);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_max !== 4'd1 || out_same !== 1'b1) begin
            fails++;
            $display("FAIL clro_idle: got v=%b r=%b max=%0d same=%b want 0 1 1 1",
                     out_valid, in_ready, out_max, out_same);
        end
    endtask

    task automatic test_clr;
        out_ready = 1'b1;
        send(4'd1); send(4'd2);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd7;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        send(4'd0); send(4'd15); send(4'd15);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL clr_early: got %b want 0", out_valid);
        end
        send(4'd0);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_max !== 4'd15 ||
            out_min !== 4'd0 || out_same !== 1'b0) begin
            fails++;
            $display("FAIL clr_res: got v=%b %0d/%0d/%b want 1 15/0/0",
                     out_valid, out_max, out_min, out_same);
        end
`ifdef CMP_TRACK_TREND_EN
        tests++;
        if (out_up !== 4'd1 || out_dn !== 4'd1) begin
            fails++;
            $display("FAIL clr_trend: got %0d/%0d want 1/1", out_up, out_dn);
        end
`endif
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        @(negedge clk);
        send(4'd3); send(4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
            out_max !== 4'd0 || out_min !== 4'd0 || out_same !== 1'b0) begin
            fails++;
            $display("FAIL rmid_zero: got v=%b r=%b %0d/%0d/%b want 0 0 0/0/0",
                     out_valid, in_ready, out_max, out_min, out_same);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        send(4'd1); send(4'd2);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL rmid_partial: got %b want 0", out_valid);
        end
        send(4'd6); send(4'd6);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_max !== 4'd6 ||
            out_min !== 4'd1 || out_same !== 1'b0) begin
            fails++;
            $display("FAIL rmid_res: got v=%b %0d/%0d/%b want 1 6/1/0",
                     out_valid, out_max, out_min, out_same);
        end
`ifdef CMP_TRACK_TREND_EN
        tests++;
        if (out_up !== 4'd2 || out_dn !== 4'd0) begin
            fails++;
            $display("FAIL rmid_trend: got %0d/%0d want 2/0", out_up, out_dn);
        end
`endif
    endtask

    task automatic test_gaps;
        logic [3:0] seq [4];
        seq[0] = 4'd15; seq[1] = 4'd0; seq[2] = 4'd15; seq[3] = 4'd0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(seq[i]);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_max !== 4'd15 ||
            out_min !== 4'd0 || out_same !== 1'b0) begin
            fails++;
            $display("FAIL gaps_res: got v=%b %0d/%0d/%b want 1 15/0/0",
                     out_valid, out_max, out_min, out_same);
        end
`ifdef CMP_TRACK_TREND_EN
        tests++;
        if (out_up !== 4'd1 || out_dn !== 4'd2) begin
            fails++;
            $display("FAIL gaps_trend: got %0d/%0d want 1/2", out_up, out_dn);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same();
        test_backpressure();
        test_clr_out();
        test_clr();
        test_reset_mid();
        test_gaps();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
